alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execution stage downstream of ALU_Control. Consumes its AluActive strobe and AC0..AC7
//  operand/carry selects, together with pipeline operands, then computes the ALU result.
//  Two-deep valid/ready pipeline: S1 holds operands, S2 holds the result.
//  Holds the architectural C/Z/N/V flags. Sustains one op per clock.
// PARAMETERS
//  WIDTH  8  datapath width in bits; must be >= 2
// PORTS
//  Clock      in   1      rising-edge clock, single domain
//  Reset_n    in   1      synchronous, active-low reset
//  InValid    in   1      upstream beat valid
//  InReady    out  1      stage can accept a beat
//  AluActive  in   1      beat is a real ALU op; 0 = consume beat, no output, no flag change
//  AluCtrl    in   8      {AC7_CS1..AC0_RHS0} from ALU_Control
//  Lhs        in   WIDTH  left operand
//  Rhs        in   WIDTH  right operand
//  OutValid   out  1      Result/flags valid
//  OutReady   in   1      downstream accepts result
//  Result     out  WIDTH  registered result
//  FlagC/Z/N/V out 1 each architectural flags, registered
// BEHAVIOUR
//  Handshake: a beat transfers when InValid&&InReady; the output transfers when OutValid&&OutReady.
//  Upstream holds all inputs stable while InValid&&!InReady.
//  S1 load: a transferring beat with AluActive=1 sets s1_valid and captures AluCtrl/Lhs/Rhs.
//   A transferring beat with AluActive=0 is dropped and leaves s1_valid unchanged.
//  adv = s1_valid && (!OutValid || OutReady). InReady = Reset_n && (!s1_valid || adv).
//  On adv: S2 <= compute(S1), OutValid<=1, flags update. OutReady&&OutValid&&!adv -> OutValid<=0.
//  Simultaneous load+adv in the same clock is legal and yields full throughput.
//  Latency: accept at edge N -> OutValid at edge N+1 when the output is free.
//  Operand selects: LhsOp by AC[5:4]: 0 Lhs, 1 zero, 2 Rhs, 3 all-ones.
//   RhsOp by AC[1:0]: 0 Rhs, 1 ~Rhs, 2 zero, 3 all-ones.
//   Cin by AC[7:6]: 0 ->0, 1 ->1, 2/3 -> FlagC (value before this op's update).
//  Op class: AC[3]=0,AC[2]=0 ADD: {c,r}=LhsOp+RhsOp+Cin (WIDTH+1 bits); C=c; V=signed overflow.
//   AC[3]=0,AC[2]=1 RRC: r={Cin,LhsOp[W-1:1]}; C=LhsOp[0]; V=0.
//   AC[3]=1 LOGIC on LhsOp,RhsOp by AC[1:0]: 0 AND, 1 OR, 2 XOR, 3 ~LhsOp; C unchanged, V=0.
//   In LOGIC ops AC[1:0] select the function, so RhsOp is taken as Rhs.
//  All classes: Z=(r==0); N=r[W-1]. Flags change only on adv.
//  Backpressure: OutReady=0 with S2 full and S1 full -> InReady=0; all state holds.
//  Reset (Reset_n=0 at edge): s1_valid=0, OutValid=0, Result=0, C=Z=N=V=0, InReady=0 while low.
//   Reset mid-operation discards S1 and S2 contents; no partial output is emitted.
//  Carry chaining: back-to-back ADD with Cin=FlagC sees the flag from the op that advanced in the previous clock.
// CONFIGURATION
//  ALU_PARITY_FLAG_EN defined: adds output FlagP (1); FlagP=~^r, i.e. even parity.
//   FlagP is updated on adv and reset to 0.
//  ALU_PARITY_FLAG_EN undefined: no FlagP port and no parity logic; all other behaviour is identical.
// TESTING
//  T1 reset: hold Reset_n=0 for 3 clocks with InValid=1 -> InReady=0, OutValid=0, Result=0, flags 0.
//  T2 ADD: Lhs=8'h7F, Rhs=8'h01, AluCtrl=8'h00 -> next clock Result=8'h80, N=1, V=1, C=0, Z=0.
//  T3 SUB chain: AluCtrl=8'h41 (~Rhs, Cin=1), 8'h10 - 8'h10 -> Result=0, Z=1, C=1.
//   Then AluCtrl=8'h81 with 8'h00-8'h01 -> Result=8'hFF, C=0, N=1.
//  T4 backpressure: OutReady=0, three beats offered -> two beats accepted, InReady=0.
//   Result holds the first beat's value; releasing OutReady drains both in order with none lost.
//  T5 AluActive=0 beat between two ADDs -> exactly two outputs, and flags come from the ADDs only.
//  T6 LOGIC/RRC: AluCtrl=8'h0A, 8'hF0^8'h3C -> 8'hCC, C unchanged.
//   Then RRC (AluCtrl=8'h44), Lhs=8'h03 -> Result=8'h81, C=1.
//   With ALU_PARITY_FLAG_EN, FlagP=1 for 8'hCC.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//
// Execution stage that sits after ALU_Control. It takes the AluActive strobe
// and the AC0..AC7 operand/carry selects, along with the pipeline operands,
// and computes the ALU result. The stage is two deep and uses valid/ready
// handshaking:
//   - S1 holds the operands of the next operation.
//   - S2 holds the registered result and the architectural C/Z/N/V flags.
// It can sustain one operation per clock.
//
// Parameters
//   WIDTH      datapath width in bits (must be >= 2)
//
// Ports
//   Clock      rising-edge clock
//   Reset_n    synchronous active-low reset
//   InValid    upstream beat valid
//   InReady    stage can accept a beat
//   AluActive  beat is a real ALU op (0 = consume the beat and drop it)
//   AluCtrl    {AC7..AC0} operand / carry / op selects
//   Lhs, Rhs   operands
//   OutValid   Result and flags are valid
//   OutReady   downstream accepts the result
//   Result     registered result
//   FlagC/Z/N/V architectural flags
//   FlagP      even-parity flag (only when ALU_PARITY_FLAG_EN is defined)
//
// Configuration
//   ALU_PARITY_FLAG_EN  when defined, adds the FlagP output and the parity logic.

module alu_exec_stage #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic             AluActive,
    input  logic [7:0]       AluCtrl,
    input  logic [WIDTH-1:0] Lhs,
    input  logic [WIDTH-1:0] Rhs,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             FlagC,
    output logic             FlagZ,
    output logic             FlagN,
    output logic             FlagV
`ifdef ALU_PARITY_FLAG_EN
    ,
    output logic             FlagP
`endif
);

    logic             s1_valid;
    logic [7:0]       s1_ctrl;
    logic [WIDTH-1:0] s1_lhs;
    logic [WIDTH-1:0] s1_rhs;

    logic             adv;
    logic             load;

    logic [WIDTH-1:0] lhs_op;
    logic [WIDTH-1:0] rhs_op;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             next_c;
    logic             next_v;

    // S1 moves into S2 whenever the output register is empty or is being
    // drained in this same clock. That lets a new beat load while the previous
    // one advances, so the stage keeps full throughput.
    assign adv     = s1_valid && (!OutValid || OutReady);
    assign InReady = Reset_n && (!s1_valid || adv);
    assign load    = InValid && InReady && AluActive;

    always_comb begin
        lhs_op = s1_lhs;
        rhs_op = s1_rhs;
        cin    = 1'b0;
        sum    = '0;
        res    = '0;
        next_c = FlagC;
        next_v = 1'b0;

        case (s1_ctrl[5:4])
            2'd0:    lhs_op = s1_lhs;
            2'd1:    lhs_op = '0;
            2'd2:    lhs_op = s1_rhs;
            default: lhs_op = '1;
        endcase

        // In logic ops, AC[1:0] selects the function, not the right operand.
        if (s1_ctrl[3]) begin
            rhs_op = s1_rhs;
        end else begin
            case (s1_ctrl[1:0])
                2'd0:    rhs_op = s1_rhs;
                2'd1:    rhs_op = ~s1_rhs;
                2'd2:    rhs_op = '0;
                default: rhs_op = '1;
            endcase
        end

        // The chained carry uses the flag value from before this op updates it.
        cin = s1_ctrl[7] ? FlagC : s1_ctrl[6];
        sum = {1'b0, lhs_op} + {1'b0, rhs_op} + {{WIDTH{1'b0}}, cin};

        if (!s1_ctrl[3] && !s1_ctrl[2]) begin
            res    = sum[WIDTH-1:0];
            next_c = sum[WIDTH];
            next_v = (lhs_op[WIDTH-1] == rhs_op[WIDTH-1]) &&
                     (sum[WIDTH-1] != lhs_op[WIDTH-1]);
        end else if (!s1_ctrl[3]) begin
            res    = {cin, lhs_op[WIDTH-1:1]};
            next_c = lhs_op[0];
        end else begin
            case (s1_ctrl[1:0])
                2'd0:    res = lhs_op & rhs_op;
                2'd1:    res = lhs_op | rhs_op;
                2'd2:    res = lhs_op ^ rhs_op;
                default: res = ~lhs_op;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_ctrl  <= '0;
            s1_lhs   <= '0;
            s1_rhs   <= '0;
            OutValid <= 1'b0;
            Result   <= '0;
            FlagC    <= 1'b0;
            FlagZ    <= 1'b0;
            FlagN    <= 1'b0;
            FlagV    <= 1'b0;
`ifdef ALU_PARITY_FLAG_EN
            FlagP    <= 1'b0;
`endif
        end else begin
            // A transferring beat with AluActive=0 is consumed but never enters S1.
            if (load) begin
                s1_valid <= 1'b1;
                s1_ctrl  <= AluCtrl;
                s1_lhs   <= Lhs;
                s1_rhs   <= Rhs;
            end else if (adv) begin
                s1_valid <= 1'b0;
            end

            if (adv) begin
                OutValid <= 1'b1;
                Result   <= res;
                FlagC    <= next_c;
                FlagZ    <= (res == '0);
                FlagN    <= res[WIDTH-1];
                FlagV    <= next_v;
`ifdef ALU_PARITY_FLAG_EN
                FlagP    <= ~^res;
`endif
            end else if (OutValid && OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage
//
// Directed testbench for alu_exec_stage with WIDTH=8. It covers:
//   - reset
//   - ADD overflow
//   - a back-to-back subtract carry chain
//   - backpressure
//   - dropped AluActive=0 beats
//   - logic and rotate-through-carry ops
//   - reset in the middle of an operation

module tb_alu_exec_stage;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       InValid;
    logic       InReady;
    logic       AluActive;
    logic [7:0] AluCtrl;
    logic [7:0] Lhs;
    logic [7:0] Rhs;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] Result;
    logic       FlagC, FlagZ, FlagN, FlagV;
`ifdef ALU_PARITY_FLAG_EN
    logic       FlagP;
`endif

    int vectors     = 0;
    int miscompares = 0;

    alu_exec_stage #(.WIDTH(8)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .InValid   (InValid),
        .InReady   (InReady),
        .AluActive (AluActive),
        .AluCtrl   (AluCtrl),
        .Lhs       (Lhs),
        .Rhs       (Rhs),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Result    (Result),
        .FlagC     (FlagC),
        .FlagZ     (FlagZ),
        .FlagN     (FlagN),
        .FlagV     (FlagV)
`ifdef ALU_PARITY_FLAG_EN
        ,
        .FlagP     (FlagP)
`endif
    );

    always #5 Clock = ~Clock;

    // Advance one clock, then settle 1 time unit past the rising edge.
    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs;
        InValid   = 1'b0;
        AluActive = 1'b0;
        AluCtrl   = 8'h00;
        Lhs       = 8'h00;
        Rhs       = 8'h00;
    endtask

    task automatic set_beat(input logic act, input logic [7:0] ctrl,
                            input logic [7:0] l, input logic [7:0] r);
        InValid   = 1'b1;
        AluActive = act;
        AluCtrl   = ctrl;
        Lhs       = l;
        Rhs       = r;
    endtask

    task automatic test_reset;
        Reset_n  = 1'b0;
        OutReady = 1'b1;
        set_beat(1'b1, 8'h00, 8'h11, 8'h22);
        repeat (3) tick;
        vectors++;
        if (InReady !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b want 0", InReady);
        end
        vectors++;
        if (OutValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_out_valid: got %b want 0", OutValid);
        end
        vectors++;
        if (Result !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_result: got %h want 00", Result);
        end
        vectors++;
        if ({FlagC, FlagZ, FlagN, FlagV} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {FlagC, FlagZ, FlagN, FlagV});
        end
`ifdef ALU_PARITY_FLAG_EN
        vectors++;
        if (FlagP !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_parity: got %b want 0", FlagP);
        end
`endif
        idle_inputs();
        Reset_n = 1'b1;
        tick;
        vectors++;
        if (InReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_in_ready: got %b want 1", InReady);
        end
    endtask

    task automatic test_add;
        OutReady = 1'b1;
        set_beat(1'b1, 8'h00, 8'h7F, 8'h01);
        tick;
        idle_inputs();
        vectors++;
        if (OutValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL add_latency: got OutValid=%b want 0", OutValid);
        end
        tick;
        vectors++;
        if (OutValid !== 1'b1 || Result !== 8'h80) begin
            miscompares++;
            $display("[TB] FAIL add_result: got valid=%b result=%h want 1/80", OutValid, Result);
        end
        vectors++;
        if ({FlagC, FlagZ, FlagN, FlagV} !== 4'b0011) begin
            miscompares++;
            $display("[TB] FAIL add_flags: got CZNV=%b want 0011", {FlagC, FlagZ, FlagN, FlagV});
        end
        tick;
        vectors++;
        if (OutValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL add_drain: got OutValid=%b want 0", OutValid);
        end
    endtask

    task automatic test_back_to_back;
        OutReady = 1'b1;
        set_beat(1'b1, 8'h41, 8'h10, 8'h10);
        tick;
        set_beat(1'b1, 8'h81, 8'h00, 8'h01);
        vectors++;
        if (InReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_in_ready: got %b want 1", InReady);
        end
        tick;
        idle_inputs();
        vectors++;
        if (OutValid !== 1'b1 || Result !== 8'h00 ||
            {FlagC, FlagZ, FlagN, FlagV} !== 4'b1100) begin
            miscompares++;
            $display("[TB] FAIL sub_zero: got valid=%b result=%h CZNV=%b want 1/00/1100",
                     OutValid, Result, {FlagC, FlagZ, FlagN, FlagV});
        end
        tick;
        vectors++;
        if (OutValid !== 1'b1 || Result !== 8'hFF ||
            {FlagC, FlagZ, FlagN, FlagV} !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL sub_borrow: got valid=%b result=%h CZNV=%b want 1/ff/0010",
                     OutValid, Result, {FlagC, FlagZ, FlagN, FlagV});
        end
        tick;
    endtask

    task automatic test_backpressure;
        OutReady = 1'b0;
        set_beat(1'b1, 8'h00, 8'h01, 8'h01);
        tick;
        set_beat(1'b1, 8'h00, 8'h02, 8'h02);
        tick;
        set_beat(1'b1, 8'h00, 8'h08, 8'h08);
        vectors++;
        if (InReady !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_in_ready: got %b want 0", InReady);
        end
        repeat (2) tick;
        vectors++;
        if (InReady !== 1'b0 || OutValid !== 1'b1 || Result !== 8'h02) begin
            miscompares++;
            $display("[TB] FAIL bp_hold: got ready=%b valid=%b result=%h want 0/1/02",
                     InReady, OutValid, Result);
        end
        OutReady = 1'b1;
        tick;
        idle_inputs();
        vectors++;
        if (OutValid !== 1'b1 || Result !== 8'h04) begin
            miscompares++;
            $display("[TB] FAIL bp_drain_second: got valid=%b result=%h want 1/04", OutValid, Result);
        end
        tick;
        vectors++;
        if (OutValid !== 1'b1 || Result !== 8'h10) begin
            miscompares++;
            $display("[TB] FAIL bp_drain_third: got valid=%b result=%h want 1/10", OutValid, Result);
        end
        tick;
        vectors++;
        if (OutValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_empty: got OutValid=%b want 0", OutValid);
        end
    endtask

    task automatic test_inactive;
        logic [7:0] ctrls [3];
        logic [7:0] lhss  [3];
        logic [7:0] rhss  [3];
        logic       acts  [3];
        logic [7:0] got_r [8];
        logic [3:0] got_f [8];
        int         n_out;
        ctrls = '{8'h00, 8'h04, 8'h80};
        lhss  = '{8'hFF, 8'h02, 8'h01};
        rhss  = '{8'h01, 8'h00, 8'h01};
        acts  = '{1'b1, 1'b0, 1'b1};
        n_out = 0;
        OutReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 3) set_beat(acts[i], ctrls[i], lhss[i], rhss[i]);
            else idle_inputs();
            tick;
            if (OutValid === 1'b1) begin
                got_r[n_out] = Result;
                got_f[n_out] = {FlagC, FlagZ, FlagN, FlagV};
                n_out++;
            end
        end
        idle_inputs();
        vectors++;
        if (n_out !== 2) begin
            miscompares++;
            $display("[TB] FAIL inactive_count: got %0d outputs want 2", n_out);
        end else begin
            vectors++;
            if (got_r[0] !== 8'h00 || got_f[0] !== 4'b1100) begin
                miscompares++;
                $display("[TB] FAIL inactive_first: got result=%h CZNV=%b want 00/1100",
                         got_r[0], got_f[0]);
            end
            vectors++;
            if (got_r[1] !== 8'h03 || got_f[1] !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL inactive_second: got result=%h CZNV=%b want 03/0000",
                         got_r[1], got_f[1]);
            end
        end
    endtask

    task automatic test_logic_rrc;
        OutReady = 1'b1;
        set_beat(1'b1, 8'h00, 8'hFF, 8'h01);
        tick;
        set_beat(1'b1, 8'h0A, 8'hF0, 8'h3C);
        tick;
        set_beat(1'b1, 8'h44, 8'h03, 8'h00);
        tick;
        vectors++;
        if (OutValid !== 1'b1 || Result !== 8'hCC ||
            {FlagC, FlagZ, FlagN, FlagV} !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL logic_xor: got valid=%b result=%h CZNV=%b want 1/cc/1010",
                     OutValid, Result, {FlagC, FlagZ, FlagN, FlagV});
        end
`ifdef ALU_PARITY_FLAG_EN
        vectors++;
        if (FlagP !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL logic_parity: got %b want 1", FlagP);
        end
`endif
        set_beat(1'b1, 8'h04, 8'h02, 8'h00);
        tick;
        idle_inputs();
        vectors++;
        if (OutValid !== 1'b1 || Result !== 8'h81 ||
            {FlagC, FlagZ, FlagN, FlagV} !== 4'b1010) begin
            miscompares++;
            $display("[TB] FAIL rrc_cin1: got valid=%b result=%h CZNV=%b want 1/81/1010",
                     OutValid, Result, {FlagC, FlagZ, FlagN, FlagV});
        end
        tick;
        vectors++;
        if (OutValid !== 1'b1 || Result !== 8'h01 ||
            {FlagC, FlagZ, FlagN, FlagV} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL rrc_cin0: got valid=%b result=%h CZNV=%b want 1/01/0000",
                     OutValid, Result, {FlagC, FlagZ, FlagN, FlagV});
        end
        tick;
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        OutReady = 1'b0;
        set_beat(1'b1, 8'h00, 8'h11, 8'h11);
        tick;
        set_beat(1'b1, 8'h00, 8'h22, 8'h22);
        tick;
        idle_inputs();
        vectors++;
        if (OutValid !== 1'b1 || Result !== 8'h22) begin
            miscompares++;
            $display("[TB] FAIL mid_prefill: got valid=%b result=%h want 1/22", OutValid, Result);
        end
        Reset_n = 1'b0;
        tick;
        vectors++;
        if (OutValid !== 1'b0 || Result !== 8'h00 || InReady !== 1'b0 ||
            {FlagC, FlagZ, FlagN, FlagV} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got valid=%b result=%h ready=%b CZNV=%b want 0/00/0/0000",
                     OutValid, Result, InReady, {FlagC, FlagZ, FlagN, FlagV});
        end
        Reset_n  = 1'b1;
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (OutValid === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("[TB] FAIL mid_no_output: got %0d outputs want 0", seen);
        end
    endtask

    initial begin
        Reset_n  = 1'b0;
        OutReady = 1'b0;
        idle_inputs();
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_inactive();
        test_logic_rrc();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
